// File: rtl/kv10_dcache_pkg.sv
// Shared constants for the kv10 data cache: bus widths and FSM state encodings.
package kv10_dcache_pkg;

    localparam int KV10_PADDR_W = 22;
    localparam int KV10_WORD_W  = 36;
    localparam int KV10_INDEX_W = 6;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOOKUP = 3'd1;
    localparam logic [2:0] ST_MRD    = 3'd2;
    localparam logic [2:0] ST_MWR    = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_FLUSH  = 3'd5;

endpackage

// File: rtl/kv10_dcache_if.sv
// Upstream (paging unit) and downstream (memory) request bus of the kv10 data cache.
interface kv10_dcache_if
    import kv10_dcache_pkg::*;
#(
    parameter int ADDR_W = KV10_PADDR_W,
    parameter int WORD_W = KV10_WORD_W
);
    logic [ADDR_W-1:0] up_addr;
    logic [WORD_W-1:0] up_write_data;
    logic              up_read;
    logic              up_write;
    logic [WORD_W-1:0] up_read_data;
    logic              up_read_ack;
    logic              up_write_ack;
    logic              up_nxm;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_write_data;
    logic              mem_read;
    logic              mem_write;
    logic [WORD_W-1:0] mem_read_data;
    logic              mem_read_ack;
    logic              mem_write_ack;
    logic              mem_nxm;

    modport slave (
        input  up_addr, up_write_data, up_read, up_write,
               mem_read_data, mem_read_ack, mem_write_ack, mem_nxm,
        output up_read_data, up_read_ack, up_write_ack, up_nxm,
               mem_addr, mem_write_data, mem_read, mem_write
    );

    modport master (
        output up_addr, up_write_data, up_read, up_write,
               mem_read_data, mem_read_ack, mem_write_ack, mem_nxm,
        input  up_read_data, up_read_ack, up_write_ack, up_nxm,
               mem_addr, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/kv10_dcache_cache_ram.sv
// Single-port synchronous-read RAM holding {valid, tag, data} cache lines.
module kv10_dcache_cache_ram #(
    parameter int DATA_W = 53,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Read-before-write port: rdata_o returns the old contents on a write.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_o <= mem_q[addr_i];
    end
endmodule

// File: rtl/kv10_dcache.sv
// Direct-mapped write-through, write-allocate data cache, one word per line.
// Optional read hit/miss counters are enabled with KV10_DCACHE_STATS_EN.
module kv10_dcache
    import kv10_dcache_pkg::*;
#(
    parameter int ADDR_W  = KV10_PADDR_W,
    parameter int WORD_W  = KV10_WORD_W,
    parameter int INDEX_W = KV10_INDEX_W
) (
    input  logic           clk,
    input  logic           reset,
    kv10_dcache_if.slave   bus,
    input  logic           flush,
    output logic           busy
`ifdef KV10_DCACHE_STATS_EN
    ,
    output logic [31:0]    hit_count,
    output logic [31:0]    miss_count
`endif
);
    localparam int TAG_W   = ADDR_W - INDEX_W;
    localparam int ENTRY_W = 1 + TAG_W + WORD_W;
    localparam logic [INDEX_W-1:0] LAST_IDX = {INDEX_W{1'b1}};

    logic [2:0]         state_q, state_d;
    logic [INDEX_W-1:0] cnt_q, cnt_d;
    logic               flush_pend_q, flush_pend_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [WORD_W-1:0]  rdata_q, rdata_d;
    logic               rack_q, rack_d;
    logic               wack_q, wack_d;
    logic               nxm_q, nxm_d;
    logic               busy_q, busy_d;

    logic               ram_we_s;
    logic [INDEX_W-1:0] ram_addr_s;
    logic [ENTRY_W-1:0] ram_wdata_s, ram_rdata_s;
    logic [TAG_W-1:0]   req_tag_s;
    logic               hit_s;

    kv10_dcache_cache_ram #(.DATA_W(ENTRY_W), .ADDR_W(INDEX_W)) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    // The latched request address doubles as the downstream address.
    assign req_tag_s = mem_addr_q[ADDR_W-1:INDEX_W];
    assign hit_s     = ram_rdata_s[ENTRY_W-1] && (ram_rdata_s[ENTRY_W-2 -: TAG_W] == req_tag_s);

    // Next-state, RAM port and output logic of the cache controller.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q | flush;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        rdata_d      = {WORD_W{1'b0}};
        rack_d       = 1'b0;
        wack_d       = 1'b0;
        nxm_d        = 1'b0;
        busy_d       = (state_q == ST_FLUSH);
        ram_we_s     = 1'b0;
        ram_addr_s   = mem_addr_q[INDEX_W-1:0];
        ram_wdata_s  = {ENTRY_W{1'b0}};
        case (state_q)
            ST_IDLE: begin
                ram_addr_s = bus.up_addr[INDEX_W-1:0];
                if (flush || flush_pend_q) begin
                    state_d      = ST_FLUSH;
                    cnt_d        = {INDEX_W{1'b0}};
                    flush_pend_d = 1'b0;
                end else if (bus.up_write) begin
                    state_d     = ST_MWR;
                    mem_write_d = 1'b1;
                    mem_addr_d  = bus.up_addr;
                    mem_wdata_d = bus.up_write_data;
                end else if (bus.up_read) begin
                    state_d    = ST_LOOKUP;
                    mem_addr_d = bus.up_addr;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (hit_s) begin
                    rack_d  = 1'b1;
                    rdata_d = ram_rdata_s[WORD_W-1:0];
                    state_d = ST_DONE;
                end else begin
                    mem_read_d = 1'b1;
                    state_d    = ST_MRD;
                end
            end
            ST_MRD: begin
                if (bus.mem_nxm) begin
                    mem_read_d = 1'b0;
                    rack_d     = 1'b1;
                    nxm_d      = 1'b1;
                    state_d    = ST_DONE;
                end else if (bus.mem_read_ack) begin
                    ram_we_s    = 1'b1;
                    ram_wdata_s = {1'b1, req_tag_s, bus.mem_read_data};
                    mem_read_d  = 1'b0;
                    rack_d      = 1'b1;
                    rdata_d     = bus.mem_read_data;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_MRD;
                end
            end
            ST_MWR: begin
                if (bus.mem_nxm) begin
                    ram_we_s    = 1'b1;
                    mem_write_d = 1'b0;
                    wack_d      = 1'b1;
                    nxm_d       = 1'b1;
                    state_d     = ST_DONE;
                end else if (bus.mem_write_ack) begin
                    ram_we_s    = 1'b1;
                    ram_wdata_s = {1'b1, req_tag_s, mem_wdata_q};
                    mem_write_d = 1'b0;
                    wack_d      = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    state_d = ST_MWR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_FLUSH: begin
                ram_we_s   = 1'b1;
                ram_addr_s = cnt_q;
                cnt_d      = cnt_q + INDEX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_FLUSH;
                cnt_d   = {INDEX_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs; reset abandons any transaction and starts a sweep.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_FLUSH;
            cnt_q        <= {INDEX_W{1'b0}};
            flush_pend_q <= 1'b0;
            mem_addr_q   <= {ADDR_W{1'b0}};
            mem_wdata_q  <= {WORD_W{1'b0}};
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            rdata_q      <= {WORD_W{1'b0}};
            rack_q       <= 1'b0;
            wack_q       <= 1'b0;
            nxm_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_pend_q <= flush_pend_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            rdata_q      <= rdata_d;
            rack_q       <= rack_d;
            wack_q       <= wack_d;
            nxm_q        <= nxm_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.up_read_data   = rdata_q;
    assign bus.up_read_ack    = rack_q;
    assign bus.up_write_ack   = wack_q;
    assign bus.up_nxm         = nxm_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign busy               = busy_q;

`ifdef KV10_DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    // Saturating read hit/miss counters, decided in LOOKUP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (state_q == ST_LOOKUP) begin
            if (hit_s && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (!hit_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_kv10_dcache.sv
// Self-checking bench for kv10_dcache: directed scenarios then random traffic vs. a line-level model.
module tb_kv10_dcache;
    localparam int AW = 22;
    localparam int WW = 36;
    localparam int IW = 6;
    localparam int NIDX = 64;
    localparam logic [21:0] NXM_BASE = 22'o10000000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic flush = 1'b0;
    logic busy;
`ifdef KV10_DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    kv10_dcache_if #(.ADDR_W(AW), .WORD_W(WW)) bus ();

    kv10_dcache #(.ADDR_W(AW), .WORD_W(WW), .INDEX_W(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .flush (flush),
        .busy  (busy)
`ifdef KV10_DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: which address each index currently holds, and backing memory.
    bit          mv [NIDX];
    logic [21:0] ma [NIDX];
    logic [35:0] md [NIDX];
    logic [35:0] bmem [logic [21:0]];
    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_miss = 0;

    function automatic logic [35:0] bget(input logic [21:0] a);
        if (bmem.exists(a)) return bmem[a];
        return {14'h2A5, a};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < NIDX; i++) mv[i] = 1'b0;
    endtask

    task automatic wait_busy_count(output int n);
        int k;
        n = 0;
        k = 0;
        while (!busy && k < 10) begin @(negedge clk); k++; end
        while (busy && n < 300) begin @(negedge clk); n++; end
    endtask

    task automatic do_read(input logic [21:0] a, input int lat, input bit flush_mid);
        int idx, cyc, wt, ackcyc;
        bit hit, nxm, seen, resp, got, nxo;
        logic [35:0] expd, obs;
        logic [21:0] maddr;
        idx = int'(a[5:0]);
        hit = mv[idx] && (ma[idx] == a);
        nxm = (a >= NXM_BASE);
        expd = hit ? md[idx] : (nxm ? 36'd0 : bget(a));
        seen = 1'b0; resp = 1'b0; got = 1'b0; nxo = 1'b0;
        cyc = 0; wt = lat; ackcyc = 0; obs = '0; maddr = '0;
        bus.up_addr = a;
        bus.up_read = 1'b1;
        @(posedge clk);
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            flush = 1'b0;
            bus.mem_read_ack = 1'b0;
            bus.mem_nxm = 1'b0;
            if (bus.up_read_ack) begin
                got = 1'b1; obs = bus.up_read_data; nxo = bus.up_nxm; ackcyc = cyc;
            end else if (bus.mem_read && !resp) begin
                if (!seen) begin seen = 1'b1; maddr = bus.mem_addr; flush = flush_mid; end
                if (wt == 0) begin
                    resp = 1'b1;
                    if (nxm) bus.mem_nxm = 1'b1;
                    else begin bus.mem_read_ack = 1'b1; bus.mem_read_data = bget(a); end
                end else wt--;
            end
        end
        bus.up_read = 1'b0;
        flush = 1'b0;
        check("rd_ack_seen", 64'(got), 64'd1);
        if (got) begin
            check("rd_data", 64'(obs), 64'(expd));
            check("rd_nxm", 64'(nxo), 64'(nxm && !hit));
            check("rd_mem_read_on_miss", 64'(seen), 64'(!hit));
            if (hit) check("rd_hit_latency", 64'(ackcyc), 64'd2);
            if (seen) check("rd_mem_addr", 64'(maddr), 64'(a));
            @(negedge clk);
            check("rd_ack_width", {62'd0, bus.up_read_ack, bus.mem_read}, 64'd0);
        end
        if (hit) exp_hits++;
        else begin
            exp_miss++;
            if (!nxm) begin mv[idx] = 1'b1; ma[idx] = a; md[idx] = expd; end
        end
    endtask

    task automatic do_write(input logic [21:0] a, input logic [35:0] d, input int lat, input bit both);
        int idx, cyc, wt;
        bit nxm, seen, resp, got, nxo, rack;
        logic [21:0] maddr;
        logic [35:0] mdata;
        idx = int'(a[5:0]);
        nxm = (a >= NXM_BASE);
        seen = 1'b0; resp = 1'b0; got = 1'b0; nxo = 1'b0; rack = 1'b0;
        cyc = 0; wt = lat; maddr = '0; mdata = '0;
        bus.up_addr = a;
        bus.up_write_data = d;
        bus.up_write = 1'b1;
        bus.up_read = both;
        @(posedge clk);
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            bus.mem_write_ack = 1'b0;
            bus.mem_nxm = 1'b0;
            if (bus.up_read_ack) rack = 1'b1;
            if (bus.up_write_ack) begin
                got = 1'b1; nxo = bus.up_nxm;
            end else if (bus.mem_write && !resp) begin
                if (!seen) begin seen = 1'b1; maddr = bus.mem_addr; mdata = bus.mem_write_data; end
                if (wt == 0) begin
                    resp = 1'b1;
                    if (nxm) bus.mem_nxm = 1'b1;
                    else bus.mem_write_ack = 1'b1;
                end else wt--;
            end
        end
        bus.up_write = 1'b0;
        bus.up_read = 1'b0;
        check("wr_ack_seen", 64'(got), 64'd1);
        if (got) begin
            check("wr_nxm", 64'(nxo), 64'(nxm));
            check("wr_mem_addr", 64'(maddr), 64'(a));
            check("wr_mem_data", 64'(mdata), 64'(d));
            check("wr_no_read_ack", 64'(rack), 64'd0);
            @(negedge clk);
            check("wr_ack_width", {62'd0, bus.up_write_ack, bus.mem_write}, 64'd0);
        end
        if (nxm) mv[idx] = 1'b0;
        else begin bmem[a] = d; mv[idx] = 1'b1; ma[idx] = a; md[idx] = d; end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, k;
        logic [21:0] ra;
        bus.up_addr = '0; bus.up_write_data = '0; bus.up_read = 1'b0; bus.up_write = 1'b0;
        bus.mem_read_data = '0; bus.mem_read_ack = 1'b0; bus.mem_write_ack = 1'b0; bus.mem_nxm = 1'b0;
        model_flush();

        // Reset for three cycles, then a full sweep.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctl_outs", {58'd0, busy, bus.up_read_ack, bus.up_write_ack, bus.up_nxm,
                                 bus.mem_read, bus.mem_write}, 64'd0);
        check("reset_bus_outs", {6'd0, bus.mem_addr, bus.mem_write_data}, 64'd0);
        check("reset_rdata", 64'(bus.up_read_data), 64'd0);
        reset = 1'b1;
        wait_busy_count(n);
        check("busy_after_reset", 64'(n), 64'd64);
        do_read(22'o1000, 2, 1'b0);

        // Write then read-hit.
        do_write(22'o1000, 36'o123456701234, 4, 1'b0);
        do_read(22'o1000, 0, 1'b0);
`ifdef KV10_DCACHE_STATS_EN
        check("hit_count_t2", 64'(hit_count), 64'(exp_hits));
`endif

        // Conflict on index 0.
        do_write(22'o1000, 36'd1, 1, 1'b0);
        do_read(22'o1100, 1, 1'b0);
        do_read(22'o1000, 1, 1'b0);

        // Nonexistent memory read, no fill.
        do_read(22'o17000000, 2, 1'b0);
        do_read(22'o17000000, 0, 1'b0);

        // Flush pulse during a miss.
        do_read(22'o2000, 3, 1'b1);
        model_flush();
        wait_busy_count(n);
        check("busy_after_flush", 64'(n), 64'd64);
        do_read(22'o2000, 1, 1'b0);

        // Read and write together: write wins; then NXM write invalidates the line.
        do_write(22'o2000, 36'o777, 1, 1'b1);
        do_read(22'o2000, 0, 1'b0);
        do_write(22'o10000000, 36'o5, 0, 1'b0);
        do_read(22'o2000, 0, 1'b0);

        // Flush during a flush sweep runs a second sweep.
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        k = 0;
        while (busy && k < 200) begin @(negedge clk); k++; end
        wait_busy_count(n);
        check("second_sweep", 64'(n), 64'd64);
        model_flush();

        // Reset in the middle of a downstream write.
        bus.up_addr = 22'o3000; bus.up_write_data = 36'o4444; bus.up_write = 1'b1;
        repeat (3) @(negedge clk);
        check("mwr_active", 64'(bus.mem_write), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("reset_mid_mwr", {61'd0, bus.mem_write, bus.up_write_ack, busy}, 64'd0);
        bus.up_write = 1'b0;
        reset = 1'b1;
        model_flush();
        exp_hits = 0;
        exp_miss = 0;
        wait_busy_count(n);
        check("busy_after_mid_reset", 64'(n), 64'd64);
        do_read(22'o3000, 0, 1'b0);

        // Random traffic on a small address pool to provoke hits and conflicts.
        for (int i = 0; i < 80; i++) begin
            ra = 22'($urandom_range(0, 3)) * 22'd64 + 22'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) ra = ra | NXM_BASE;
            if ($urandom_range(0, 1) == 0)
                do_read(ra, int'($urandom_range(0, 3)), 1'b0);
            else
                do_write(ra, {4'($urandom_range(0, 15)), 32'($urandom)}, int'($urandom_range(0, 3)), 1'b0);
        end
`ifdef KV10_DCACHE_STATS_EN
        check("hit_count_end", 64'(hit_count), 64'(exp_hits));
        check("miss_count_end", 64'(miss_count), 64'(exp_miss));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
